// File: rtl/wb_timer_if.sv
// Wishbone classic bus bundle for the timer peripheral port.
interface wb_timer_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4
);
    logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
    logic [WB_DATA_WIDTH-1:0] wb_data_i;
    logic                     wb_we_i;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_i;
    logic                     wb_stb_i;
    logic                     wb_cyc_i;
    logic                     wb_ack_o;
    logic [WB_DATA_WIDTH-1:0] wb_data_o;

    modport slave (
        input  wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_ack_o, wb_data_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_ack_o, wb_data_o
    );
endinterface

// File: rtl/wb_timer.sv
// RISC-V style mtime/mtimecmp timer on a Wishbone classic slave port.
// Optional WB_TIMER_HI_LATCH_EN: lo read snapshots mtime hi for tear-free 64-bit reads.
module wb_timer #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = 4,
    parameter int PRESCALE      = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    wb_timer_if.slave wb,
    output logic      timer_irq_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_cnt;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [2:0]    offs;
    logic          req, commit, wr, rd, tick;
    logic [31:0]   hi_rd;
    logic [31:0]   rdata;

    wire unused_addr = &{1'b0, wb.wb_addr_i[WB_ADDR_WIDTH-1:5], wb.wb_addr_i[1:0]};

    assign offs   = wb.wb_addr_i[4:2];
    assign req    = wb.wb_stb_i & wb.wb_cyc_i;
    assign commit = req & ~wb.wb_ack_o;
    assign wr     = commit & wb.wb_we_i;
    assign rd     = commit & ~wb.wb_we_i;
    assign tick   = (ps_cnt == PS_LAST);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

`ifdef WB_TIMER_HI_LATCH_EN
    logic [31:0] mtime_hi_shadow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            mtime_hi_shadow <= '0;
        else if (rd && offs == 3'd0)
            mtime_hi_shadow <= mtime[63:32];
    end

    assign hi_rd = mtime_hi_shadow;
`else
    assign hi_rd = mtime[63:32];
`endif

    always_comb begin
        rdata = '0;
        case (offs)
            3'd0:    rdata = mtime[31:0];
            3'd1:    rdata = hi_rd;
            3'd2:    rdata = mtimecmp[31:0];
            3'd3:    rdata = mtimecmp[63:32];
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_cnt       <= '0;
            mtime        <= '0;
            mtimecmp     <= '1;
            wb.wb_ack_o  <= 1'b0;
            wb.wb_data_o <= '0;
            timer_irq_o  <= 1'b0;
        end else begin
            ps_cnt      <= tick ? '0 : ps_cnt + 1'b1;
            wb.wb_ack_o <= commit;
            if (rd)
                wb.wb_data_o <= rdata;
            // A bus write to either mtime word suppresses that cycle's increment entirely.
            if (wr && offs == 3'd0)
                mtime[31:0] <= merge(mtime[31:0], wb.wb_data_i[31:0], wb.wb_sel_i[3:0]);
            else if (wr && offs == 3'd1)
                mtime[63:32] <= merge(mtime[63:32], wb.wb_data_i[31:0], wb.wb_sel_i[3:0]);
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr && offs == 3'd2)
                mtimecmp[31:0] <= merge(mtimecmp[31:0], wb.wb_data_i[31:0], wb.wb_sel_i[3:0]);
            if (wr && offs == 3'd3)
                mtimecmp[63:32] <= merge(mtimecmp[63:32], wb.wb_data_i[31:0], wb.wb_sel_i[3:0]);
            timer_irq_o <= (mtime >= mtimecmp);
        end
    end
endmodule

// File: tb/tb_wb_timer.sv
// Bench for wb_timer: PRESCALE=1 and PRESCALE=4 instances share one bus stimulus,
// read data is checked against a time-based mtime model through a scoreboard queue.
module tb_wb_timer;
    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    logic irq1, irq4;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

`ifdef WB_TIMER_HI_LATCH_EN
    localparam bit HI_LATCH = 1'b1;
`else
    localparam bit HI_LATCH = 1'b0;
`endif

    always #5 clk = ~clk;

    // Index of the latest rising edge since reset release (first edge after release = 1).
    always @(posedge clk or posedge rst_i)
        if (rst_i) edge_n <= 0;
        else       edge_n <= edge_n + 1;

    wb_timer_if bif1 ();
    wb_timer_if bif4 ();

    assign bif4.wb_addr_i = bif1.wb_addr_i;
    assign bif4.wb_data_i = bif1.wb_data_i;
    assign bif4.wb_we_i   = bif1.wb_we_i;
    assign bif4.wb_sel_i  = bif1.wb_sel_i;
    assign bif4.wb_stb_i  = bif1.wb_stb_i;
    assign bif4.wb_cyc_i  = bif1.wb_cyc_i;

    wb_timer #(.PRESCALE(1)) dut1 (.clk_i(clk), .rst_i(rst_i), .wb(bif1), .timer_irq_o(irq1));
    wb_timer #(.PRESCALE(4)) dut4 (.clk_i(clk), .rst_i(rst_i), .wb(bif4), .timer_irq_o(irq4));

    // Model: mtime was set to m*_val by edge m*_edge and counts from there.
    logic [63:0] m1_val, m4_val, cmp_m;
    int          m1_edge, m4_edge;
    logic [31:0] shd1, shd4;

    typedef struct packed { logic [31:0] e1; logic [31:0] e4; } exp_t;
    exp_t  sb[$];
    string sb_name[$];

    task automatic model_reset();
        m1_val = '0; m4_val = '0; m1_edge = 0; m4_edge = 0;
        cmp_m = '1; shd1 = '0; shd4 = '0;
    endtask

    // mtime value seen by the logic at edge r (before that edge updates it)
    function automatic logic [63:0] at1(input int r);
        return m1_val + 64'(r - m1_edge - 1);
    endfunction

    function automatic logic [63:0] at4(input int r);
        return m4_val + 64'((r - 1) / 4 - m4_edge / 4);
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_model(input logic [63:0] mt, input logic [31:0] shd,
                                             input logic [2:0] off);
        case (off)
            3'd0:    return mt[31:0];
            3'd1:    return HI_LATCH ? shd : mt[63:32];
            3'd2:    return cmp_m[31:0];
            3'd3:    return cmp_m[63:32];
            default: return 32'h0;
        endcase
    endfunction

    // One transfer, started at a falling edge; ack must be visible at the next falling edge.
    task automatic bus_cycle(input logic we, input logic [2:0] off, input logic [31:0] d,
                             input logic [3:0] sel, output logic [31:0] q1,
                             output logic [31:0] q4, output logic irq_ack);
        bif1.wb_addr_i = {27'h0, off, 2'b00};
        bif1.wb_data_i = d;
        bif1.wb_we_i   = we;
        bif1.wb_sel_i  = sel;
        bif1.wb_stb_i  = 1'b1;
        bif1.wb_cyc_i  = 1'b1;
        @(negedge clk);
        checks++;
        if (!(bif1.wb_ack_o === 1'b1 && bif4.wb_ack_o === 1'b1)) begin
            errors++;
            $display("FAIL ack_latency off=%0d: ack1=%b ack4=%b, required 1", off,
                     bif1.wb_ack_o, bif4.wb_ack_o);
        end
        q1 = bif1.wb_data_o;
        q4 = bif4.wb_data_o;
        irq_ack = irq1;
        bif1.wb_stb_i = 1'b0;
        bif1.wb_cyc_i = 1'b0;
        bif1.wb_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel,
                            output logic irq_ack);
        int r;
        logic [63:0] v;
        logic [31:0] q1, q4;
        r = edge_n + 1;
        if (off == 3'd0 || off == 3'd1) begin
            v = at1(r);
            if (off == 3'd0) v[31:0] = mrg(v[31:0], d, sel);
            else             v[63:32] = mrg(v[63:32], d, sel);
            m1_val = v; m1_edge = r;
            v = at4(r);
            if (off == 3'd0) v[31:0] = mrg(v[31:0], d, sel);
            else             v[63:32] = mrg(v[63:32], d, sel);
            m4_val = v; m4_edge = r;
        end else if (off == 3'd2) begin
            cmp_m[31:0] = mrg(cmp_m[31:0], d, sel);
        end else if (off == 3'd3) begin
            cmp_m[63:32] = mrg(cmp_m[63:32], d, sel);
        end
        bus_cycle(1'b1, off, d, sel, q1, q4, irq_ack);
    endtask

    task automatic wb_read(input logic [2:0] off, input string name);
        int r;
        logic [63:0] v1, v4;
        logic [31:0] q1, q4;
        logic ia;
        exp_t e;
        string n;
        r = edge_n + 1;
        v1 = at1(r);
        v4 = at4(r);
        e.e1 = rd_model(v1, shd1, off);
        e.e4 = rd_model(v4, shd4, off);
        sb.push_back(e);
        sb_name.push_back(name);
        if (off == 3'd0) begin shd1 = v1[63:32]; shd4 = v4[63:32]; end
        bus_cycle(1'b0, off, 32'h0, 4'h0, q1, q4, ia);
        e = sb.pop_front();
        n = sb_name.pop_front();
        checks++;
        if (q1 !== e.e1) begin
            errors++;
            $display("FAIL %s (PRESCALE=1): got %h, required %h", n, q1, e.e1);
        end
        checks++;
        if (q4 !== e.e4) begin
            errors++;
            $display("FAIL %s (PRESCALE=4): got %h, required %h", n, q4, e.e4);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (bif1.wb_ack_o !== 1'b0 || bif4.wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL %s ack: got %b/%b, required 0", name, bif1.wb_ack_o, bif4.wb_ack_o);
        end
        checks++;
        if (bif1.wb_data_o !== 32'h0 || bif4.wb_data_o !== 32'h0) begin
            errors++;
            $display("FAIL %s data: got %h/%h, required 0", name, bif1.wb_data_o, bif4.wb_data_o);
        end
        checks++;
        if (irq1 !== 1'b0 || irq4 !== 1'b0) begin
            errors++;
            $display("FAIL %s irq: got %b/%b, required 0", name, irq1, irq4);
        end
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        rst_i = 1'b0;
        model_reset();
        wb_read(3'd0, "rst_mtime_lo");
        wb_read(3'd1, "rst_mtime_hi");
        wb_read(3'd2, "rst_cmp_lo");
        wb_read(3'd3, "rst_cmp_hi");
    endtask

    task automatic test_byte_lanes();
        logic ia;
        wb_write(3'd2, 32'hAABB_CCDD, 4'b0101, ia);
        wb_read(3'd2, "byte_lanes");
    endtask

    task automatic test_carry_wrap();
        logic ia;
        wb_write(3'd1, 32'h0, 4'hF, ia);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF, ia);
        wb_read(3'd1, "carry_hi");
        wb_write(3'd1, 32'hFFFF_FFFF, 4'hF, ia);
        wb_write(3'd0, 32'hFFFF_FFFF, 4'hF, ia);
        wb_read(3'd0, "wrap_lo");
        wb_read(3'd1, "wrap_hi");
        // lo read just before the carry ripples into hi
        wb_write(3'd1, 32'h0, 4'hF, ia);
        wb_write(3'd0, 32'hFFFF_FFFD, 4'hF, ia);
        wb_read(3'd0, "latch_lo");
        wb_read(3'd1, "latch_hi");
    endtask

    task automatic test_collision();
        logic ia;
        for (int i = 0; i < 4 && (edge_n % 4) != 3; i++) @(negedge clk);
        wb_write(3'd0, 32'd5, 4'hF, ia);
        wb_read(3'd0, "collide_rd0");
        wb_read(3'd0, "collide_rd1");
        wb_read(3'd0, "collide_rd2");
    endtask

    task automatic test_interrupt();
        logic ia;
        int rise, e_exp;
        logic exp4;
        wb_write(3'd1, 32'h0, 4'hF, ia);
        wb_write(3'd0, 32'h0, 4'hF, ia);
        wb_write(3'd3, 32'h0, 4'hF, ia);
        wb_write(3'd2, 32'd100, 4'hF, ia);
        e_exp = m1_edge + 1 + int'(64'd100 - m1_val);
        rise = -1;
        for (int i = 0; i < 300 && rise < 0; i++) begin
            @(negedge clk);
            if (irq1 === 1'b1) rise = edge_n;
        end
        checks++;
        if (rise != e_exp) begin
            errors++;
            $display("FAIL irq_rise_edge: got %0d, required %0d", rise, e_exp);
        end
        exp4 = (at4(edge_n) >= cmp_m);
        checks++;
        if (irq4 !== exp4) begin
            errors++;
            $display("FAIL irq_prescale4: got %b, required %b", irq4, exp4);
        end
        wb_write(3'd3, 32'h1, 4'hF, ia);
        checks++;
        if (ia !== 1'b1) begin
            errors++;
            $display("FAIL irq_at_cmp_ack: got %b, required 1", ia);
        end
        checks++;
        if (irq1 !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b, required 0", irq1);
        end
    endtask

    task automatic test_handshake();
        int acks;
        logic ia;
        acks = 0;
        bif1.wb_addr_i = {27'h0, 3'd5, 2'b00};
        bif1.wb_we_i   = 1'b0;
        bif1.wb_stb_i  = 1'b1;
        bif1.wb_cyc_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bif1.wb_ack_o === 1'b1) acks++;
        end
        bif1.wb_stb_i = 1'b0;
        bif1.wb_cyc_i = 1'b0;
        @(negedge clk);
        checks++;
        if (acks != 3) begin
            errors++;
            $display("FAIL held_strobe_acks: got %0d, required 3", acks);
        end
        wb_read(3'd0, "pre_unmapped_lo");
        wb_read(3'd5, "unmapped_rd");
        wb_write(3'd4, 32'h1234_5678, 4'hF, ia);
        wb_read(3'd2, "cmp_after_unmapped_wr");
    endtask

    task automatic test_reset_mid();
        logic ia;
        wb_write(3'd3, 32'h0, 4'hF, ia);
        wb_read(3'd2, "pre_rst_cmp_lo");
        bif1.wb_addr_i = {27'h0, 3'd2, 2'b00};
        bif1.wb_data_i = 32'h0;
        bif1.wb_we_i   = 1'b1;
        bif1.wb_sel_i  = 4'hF;
        bif1.wb_stb_i  = 1'b1;
        bif1.wb_cyc_i  = 1'b1;
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1 check_quiet("mid_reset");
        bif1.wb_stb_i = 1'b0;
        bif1.wb_cyc_i = 1'b0;
        bif1.wb_we_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        wb_read(3'd3, "mid_rst_cmp_hi");
        wb_read(3'd2, "mid_rst_cmp_lo");
        wb_read(3'd0, "mid_rst_mtime_lo");
    endtask

    initial begin
        bif1.wb_addr_i = '0;
        bif1.wb_data_i = '0;
        bif1.wb_we_i   = 1'b0;
        bif1.wb_sel_i  = '0;
        bif1.wb_stb_i  = 1'b0;
        bif1.wb_cyc_i  = 1'b0;
        model_reset();
        test_reset();
        test_byte_lanes();
        test_carry_wrap();
        test_collision();
        test_interrupt();
        test_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone classic slave that serves as the timer peripheral on the bus mux's timer port (address region addr[31:30] == 2'b01).
- Provides a RISC-V style 64-bit free-running mtime counter and a 64-bit mtimecmp compare register.
- Drives a level machine-timer interrupt to the CPU.
- Register-mapped and word-addressed through addr[4:2]; the upper address bits are already decoded upstream and are ignored here.

Parameters:
- WB_DATA_WIDTH, 32, bus data width (only 32 is supported).
- WB_ADDR_WIDTH, 32, bus address width.
- WB_SEL_WIDTH, 4, byte-select width.
- PRESCALE, 1, clock cycles per mtime increment (must be ≥ 1; 1 means increment every cycle).

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- wb_addr_i  input  WB_ADDR_WIDTH  byte address; only bits [4:2] are decoded.
- wb_data_i  input  WB_DATA_WIDTH  write data.
- wb_we_i  input  1  write enable.
- wb_sel_i  input  WB_SEL_WIDTH  byte lane enables for writes.
- wb_stb_i  input  1  strobe.
- wb_cyc_i  input  1  cycle valid.
- wb_ack_o  output  1  transfer acknowledge, registered.
- wb_data_o  output  WB_DATA_WIDTH  read data, registered.
- timer_irq_o  output  1  machine timer interrupt, level, registered.

Behaviour:
- Reset (asynchronous, while rst_i = 1):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescale counter = 0.
  - wb_ack_o = 0, wb_data_o = 0, timer_irq_o = 0.
  - Reset asserted mid-transfer drops ack immediately; the interrupted write has no effect.
- Register map (word offset = addr[4:2]):
  - 0: mtime[31:0]
  - 1: mtime[63:32]
  - 2: mtimecmp[31:0]
  - 3: mtimecmp[63:32]
  - 4..7: unmapped. Reads return 0, writes are ignored, the access is still acked.
- Handshake:
  - A request is wb_stb_i & wb_cyc_i.
  - wb_ack_o <= request & ~wb_ack_o. Ack is one cycle after the request and lasts one cycle, so a held strobe produces ack on every other cycle.
  - On the same edge that sets ack, a read loads wb_data_o with the selected register. wb_data_o holds its value when not acking.
  - A write commits on the same edge that sets ack. It commits once per ack, not on the idle cycle between acks.
  - Every register is read/write. Only the byte lanes with wb_sel_i[n] = 1 are updated; other lanes keep their value.
- Prescaler:
  - The counter runs 0..PRESCALE-1 and wraps to 0.
  - A tick occurs in the cycle where the counter equals PRESCALE-1. mtime increments by 1 on each tick.
  - With PRESCALE = 1 the counter is constant 0 and every cycle is a tick.
- mtime arithmetic:
  - 64-bit increment with full carry from bit 31 into bit 32.
  - Wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- Simultaneous write and tick: a committing write to offset 0 or 1 has priority over the tick for the entire 64-bit mtime.
  - The written lanes take the bus data, the unwritten lanes keep their old value, and there is no increment that cycle.
  - The prescaler still advances.
- Interrupt:
  - timer_irq_o <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values.
  - Latency is one cycle after mtime or mtimecmp changes.
  - Writing mtimecmp above mtime clears the irq on the following cycle.
- wb_cpu-side ordering: no internal queuing; at most one transfer is in flight.

Optional Feature:
- Macro: WB_TIMER_HI_LATCH_EN.
- Defined:
  - A read of offset 0 also snapshots mtime[63:32] into a shadow register, on the same edge as that read.
  - Reads of offset 1 return the shadow, giving a tear-free 64-bit read when software reads lo then hi.
  - The shadow resets to 0. Writes to offset 1 still write mtime directly and do not change the shadow.
- Not defined: no shadow register; reads of offset 1 return live mtime[63:32].

Test Plan:
- Reset check: assert rst_i mid-simulation -> wb_ack_o = 0, wb_data_o = 0, timer_irq_o = 0, and a read of offset 3 returns 32'hFFFF_FFFF.
- Carry and wrap: PRESCALE = 1, write mtime lo = 32'hFFFF_FFFF and hi = 32'h0000_0000 -> two cycles after the hi write, a hi read returns 1. Repeat with both words = 32'hFFFF_FFFF -> mtime wraps to 0.
- Interrupt:
  - Write mtimecmp = 100 with mtime = 0 -> timer_irq_o rises exactly one cycle after mtime reaches 100.
  - Then write mtimecmp hi = 1 -> irq falls one cycle after that write's ack.
- Byte lanes: write 32'hAABBCCDD to offset 2 with wb_sel_i = 4'b0101 over the reset value -> a read returns 32'hFFBBFFDD.
- Write/tick collision: PRESCALE = 4, write mtime lo = 5 on a tick cycle -> reads back 5, not 6. The next increment follows 4 cycles after the previous tick.
- Handshake and unmapped access:
  - Hold stb/cyc for 6 cycles -> exactly 3 single-cycle acks.
  - A read at offset 5 returns 0 and is acked.
  - With WB_TIMER_HI_LATCH_EN defined, reading lo while hi would change leaves the later hi read returning the pre-carry value.
